serial_chunk_adder: RTL and testbench

//  Multi-cycle, parametrised ripple adder: adds two WIDTH-bit operands CHUNK bits per clock.
//  The inter-chunk carry is held in a register between cycles.

---
 rtl/serial_chunk_adder.sv | 133 +++++++++++++
 tb/tb_serial_chunk_adder.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_chunk_adder.sv
// serial_chunk_adder: multi-cycle ripple adder that adds two WIDTH-bit operands
// CHUNK bits per clock, holding the inter-chunk carry in a register.
// Valid/ready handshake on both the operand and result sides.
// Optional feature macro: ADD_SUB_EN (adds the sub port; sub=1 computes a-b).
module serial_chunk_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
  localparam int unsigned NCHUNK     = WIDTH / CHUNK_SAFE;
  localparam int unsigned IDX_W      = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  // Reject parameter sets that do not split into whole chunks
  generate
    if (CHUNK < 1) begin : g_bad_chunk
      $error("serial_chunk_adder: CHUNK must be at least 1");
    end else if ((WIDTH % CHUNK_SAFE) != 0) begin : g_bad_width
      $error("serial_chunk_adder: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;
  logic             sub_sel;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic             msb_carry_in;
  logic             last_chunk;

`ifdef ADD_SUB_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)   state_d = RUN;
      RUN:     if (last_chunk) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Current chunk addition; carry into the MSB recovered from the MSB sum bit
  always_comb begin
    a_chunk      = a_q[idx_q*CHUNK +: CHUNK];
    b_chunk      = b_q[idx_q*CHUNK +: CHUNK];
    chunk_sum    = (CHUNK+1)'(a_chunk) + (CHUNK+1)'(b_chunk) + (CHUNK+1)'(carry_q);
    msb_carry_in = chunk_sum[CHUNK-1] ^ a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1];
    last_chunk   = (idx_q == LAST_IDX);
  end

  // Operand capture, per-chunk accumulation and registered handshake outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= sub_sel ? ~b : b;
            carry_q <= sub_sel ? 1'b1 : cin;
            idx_q   <= '0;
          end
        end
        RUN: begin
          sum[idx_q*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
          carry_q                   <= chunk_sum[CHUNK];
          if (last_chunk) begin
            cout <= chunk_sum[CHUNK];
            ovf  <= msb_carry_in ^ chunk_sum[CHUNK];
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Self-checking bench for serial_chunk_adder: an 8-bit/2-bit-chunk instance
// driven through a scoreboard, plus a 16-bit single-chunk instance.
module tb_serial_chunk_adder;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic       clk;
  logic       resetn;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       sub;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;

  logic        w_in_valid;
  logic        w_in_ready;
  logic [15:0] w_a;
  logic [15:0] w_b;
  logic        w_cin;
  logic        w_out_valid;
  logic        w_out_ready;
  logic [15:0] w_sum;
  logic        w_cout;
  logic        w_ovf;

  int   checks;
  int   errors;
  exp_t sb[$];

  serial_chunk_adder #(.WIDTH(8), .CHUNK(2)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  serial_chunk_adder #(.WIDTH(16), .CHUNK(16)) dut_w16 (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (w_in_valid),
    .in_ready  (w_in_ready),
    .a         (w_a),
    .b         (w_b),
    .cin       (w_cin),
`ifdef ADD_SUB_EN
    .sub       (1'b0),
`endif
    .out_valid (w_out_valid),
    .out_ready (w_out_ready),
    .sum       (w_sum),
    .cout      (w_cout),
    .ovf       (w_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: two's complement add/subtract with signed overflow by sign rule
  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y,
                                 input logic c, input logic s);
    exp_t       r;
    logic [7:0] yy;
    logic [8:0] full;
    yy     = s ? ~y : y;
    full   = {1'b0, x} + {1'b0, yy} + 9'(s ? 1'b1 : c);
    r.sum  = full[7:0];
    r.cout = full[8];
    r.ovf  = (x[7] == yy[7]) && (full[7] != x[7]);
    return r;
  endfunction

  // Present one operation, push its expectation, return at the negedge after acceptance
  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic c,
                      input logic s, input exp_t e);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("send_wait_ready", 32'(in_ready), 32'd1);
    a        = x;
    b        = y;
    cin      = c;
    sub      = s;
    in_valid = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    a        = 8'($urandom_range(0, 255));
    b        = 8'($urandom_range(0, 255));
    cin      = 1'($urandom_range(0, 1));
  endtask

  // Wait for a result, compare with scoreboard, optionally stall, then release
  task automatic recv(input int lat, input int hold);
    int   n;
    exp_t e;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'(lat));
    if (sb.size() == 0) begin
      check("sb_empty", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    check("sum", 32'(sum), 32'(e.sum));
    check("cout", 32'(cout), 32'(e.cout));
    check("ovf", 32'(ovf), 32'(e.ovf));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a        = 8'($urandom_range(0, 255));
      b        = 8'($urandom_range(0, 255));
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_ready", 32'(in_ready), 32'd0);
      check("hold_sum", 32'(sum), 32'(e.sum));
      check("hold_cout", 32'(cout), 32'(e.cout));
      check("hold_ovf", 32'(ovf), 32'(e.ovf));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    exp_t e;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    int         n;
    checks      = 0;
    errors      = 0;
    resetn      = 1'b0;
    in_valid    = 1'b0;
    a           = '0;
    b           = '0;
    cin         = 1'b0;
    sub         = 1'b0;
    out_ready   = 1'b0;
    w_in_valid  = 1'b0;
    w_a         = '0;
    w_b         = '0;
    w_cin       = 1'b0;
    w_out_ready = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("w16_rst_in_ready", 32'(w_in_ready), 32'd1);
    resetn = 1'b1;
    @(negedge clk);

    // Directed adds with hand-derived results
    e = '{sum: 8'h96, cout: 1'b0, ovf: 1'b1};
    send(8'h3C, 8'h5A, 1'b0, 1'b0, e);
    recv(4, 0);
    e = '{sum: 8'h00, cout: 1'b1, ovf: 1'b0};
    send(8'hFF, 8'h01, 1'b0, 1'b0, e);
    recv(4, 0);
    e = '{sum: 8'h01, cout: 1'b0, ovf: 1'b0};
    send(8'h00, 8'h00, 1'b1, 1'b0, e);
    recv(4, 0);

    // Backpressure: result held 5 cycles while new operands are offered
    e = '{sum: 8'h47, cout: 1'b0, ovf: 1'b0};
    send(8'h12, 8'h34, 1'b1, 1'b0, e);
    recv(4, 5);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_queued_op", 32'(out_valid), 32'd0);
    end

    // Reset while the third chunk is pending
    e = '{sum: 8'hFF, cout: 1'b0, ovf: 1'b0};
    send(8'hAA, 8'h55, 1'b0, 1'b0, e);
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    sb.delete();
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    check("abort_ovf", 32'(ovf), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_valid", 32'(out_valid), 32'd0);
    end
    e = '{sum: 8'h30, cout: 1'b0, ovf: 1'b0};
    send(8'h10, 8'h20, 1'b0, 1'b0, e);
    recv(4, 0);

    // Random adds against the reference model
    for (int i = 0; i < 12; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      send(ra, rb, rc, 1'b0, model(ra, rb, rc, 1'b0));
      recv(4, (i % 3 == 0) ? 2 : 0);
    end

`ifdef ADD_SUB_EN
    e = '{sum: 8'hFE, cout: 1'b0, ovf: 1'b0};
    send(8'h05, 8'h07, 1'b0, 1'b1, e);
    recv(4, 0);
    e = '{sum: 8'h7F, cout: 1'b1, ovf: 1'b1};
    send(8'h80, 8'h01, 1'b1, 1'b1, e);
    recv(4, 0);
    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      send(ra, rb, rc, 1'b1, model(ra, rb, rc, 1'b1));
      recv(4, 0);
    end
    sub = 1'b0;
`endif

    // Single-chunk 16-bit instance: one RUN cycle
    w_a        = 16'hFFFF;
    w_b        = 16'h0001;
    w_cin      = 1'b0;
    w_in_valid = 1'b1;
    @(negedge clk);
    w_in_valid = 1'b0;
    w_a        = 16'h1234;
    n = 0;
    while (!w_out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("w16_latency", 32'(n), 32'd1);
    check("w16_sum", 32'(w_sum), 32'h0000);
    check("w16_cout", 32'(w_cout), 32'd1);
    check("w16_ovf", 32'(w_ovf), 32'd0);
    w_out_ready = 1'b1;
    @(negedge clk);
    w_out_ready = 1'b0;
    check("w16_release_valid", 32'(w_out_valid), 32'd0);
    check("w16_release_ready", 32'(w_in_ready), 32'd1);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
